// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 key decoder: prefix FSM states,
// prefix bytes, codes with special meaning and the event word stored in the FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } state_t;

  localparam logic [7:0] PREFIX_EXT  = 8'hE0;
  localparam logic [7:0] PREFIX_BRK  = 8'hF0;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;
  localparam logic [7:0] CODE_SPACE  = 8'h29;
  localparam logic [7:0] CODE_ENTER  = 8'h5A;

  // Keyboard status/ack bytes that carry no key meaning when no prefix is pending.
  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;
  localparam logic [7:0] CODE_PAUSE  = 8'hE1;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
    logic [7:0] ascii;
  } event_t;

  function automatic logic is_special(input logic [7:0] b);
    return (b == CODE_BAT_OK) || (b == CODE_ACK) || (b == CODE_RESEND) ||
           (b == CODE_ECHO) || (b == CODE_PAUSE) || (b == 8'h00);
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 scan code to ASCII map for make events: letters, digits,
// space and enter; everything else maps to 0x00.
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       upper,
  output logic [7:0] ascii
);

  logic       letter_hit;
  logic [4:0] letter_idx;
  logic       digit_hit;
  logic [3:0] digit_val;

  always_comb begin
    letter_hit = 1'b1;
    letter_idx = 5'd0;
    case (code)
      8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
      default: letter_hit = 1'b0;
    endcase
  end

  always_comb begin
    digit_hit = 1'b1;
    digit_val = 4'd0;
    case (code)
      8'h45: digit_val = 4'd0;  8'h16: digit_val = 4'd1;
      8'h1E: digit_val = 4'd2;  8'h26: digit_val = 4'd3;
      8'h25: digit_val = 4'd4;  8'h2E: digit_val = 4'd5;
      8'h36: digit_val = 4'd6;  8'h3D: digit_val = 4'd7;
      8'h3E: digit_val = 4'd8;  8'h46: digit_val = 4'd9;
      default: digit_hit = 1'b0;
    endcase
  end

  // Only keypad enter has a meaning among extended codes.
  always_comb begin
    ascii = 8'h00;
    if (ext) begin
      ascii = (code == CODE_ENTER) ? 8'h0D : 8'h00;
    end else if (letter_hit) begin
      ascii = (upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
    end else if (digit_hit) begin
      ascii = 8'h30 + {4'b0000, digit_val};
    end else if (code == CODE_SPACE) begin
      ascii = 8'h20;
    end else if (code == CODE_ENTER) begin
      ascii = 8'h0D;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to key events: prefix FSM, shift/caps tracking, ASCII
// lookup and an event FIFO. Consumer handshake: a pop happens on any cycle with
// ev_ready=1 and ev_valid=1; ev_* show the head and advance after that edge.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic [7:0] leds,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  state_t     state, next_state;
  logic       byte_hit, emit, cur_ext, cur_brk, upper;
  logic [7:0] lut_ascii;
  event_t     new_ev, pend_ev, head;
  logic       pend_valid;
  logic       lshift, rshift, caps, caps_held;

  event_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, pop, push_ok;

  assign byte_hit = (data_in != 8'h00);
  assign cur_ext  = (state == ST_E0) || (state == ST_E0F0);
  assign cur_brk  = (state == ST_F0) || (state == ST_E0F0);
  assign upper    = (lshift | rshift) ^ caps;

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    if (byte_hit) begin
      if (data_in == PREFIX_EXT) begin
        next_state = ST_E0;
      end else if (data_in == PREFIX_BRK && state != ST_E0F0) begin
        next_state = (state == ST_E0) ? ST_E0F0 : ST_F0;
      end else if (state == ST_IDLE && is_special(data_in)) begin
        next_state = ST_IDLE;
      end else begin
        emit       = 1'b1;
        next_state = ST_IDLE;
      end
    end
  end

  ps2_ascii_lut u_lut (
    .code  (data_in),
    .ext   (cur_ext),
    .upper (upper),
    .ascii (lut_ascii)
  );

  always_comb begin
    new_ev.ext   = cur_ext;
    new_ev.brk   = cur_brk;
    new_ev.code  = data_in;
    new_ev.ascii = cur_brk ? 8'h00 : lut_ascii;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_ev    <= '0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      caps       <= 1'b0;
      caps_held  <= 1'b0;
    end else begin
      state      <= next_state;
      pend_valid <= emit;
      if (emit) pend_ev <= new_ev;
      if (emit && !cur_ext) begin
        if (data_in == CODE_LSHIFT) lshift <= !cur_brk;
        if (data_in == CODE_RSHIFT) rshift <= !cur_brk;
        // caps_held masks typematic repeats so only the first make toggles.
        if (data_in == CODE_CAPS) begin
          if (!cur_brk) begin
            if (!caps_held) caps <= !caps;
            caps_held <= 1'b1;
          end else begin
            caps_held <= 1'b0;
          end
        end
      end
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = ev_ready && (count != '0);
  assign push_ok = pend_valid && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      leds     <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pend_valid && full && !pop) overflow <= 1'b1;
      if (pend_valid && !pend_ev.brk && pend_ev.ascii != 8'h00) leds <= pend_ev.ascii;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= pend_ev;
  end

  assign head     = mem[rd_ptr];
  assign ev_valid = (count != '0);
  assign ev_code  = ev_valid ? head.code  : 8'h00;
  assign ev_ascii = ev_valid ? head.ascii : 8'h00;
  assign ev_ext   = ev_valid && head.ext;
  assign ev_break = ev_valid && head.brk;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus a randomized byte stream
// checked against a flag-based behavioural model with an event queue.
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code, ev_ascii, leds;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_break (ev_break),
    .ev_ascii (ev_ascii),
    .leds     (leds),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Event word layout: {ext, brk, code[7:0], ascii[7:0]}
  logic [17:0] exp_q[$];
  logic [17:0] obs;
  assign obs = {ev_ext, ev_break, ev_code, ev_ascii};

  bit          m_ext, m_brk, m_lsh, m_rsh, m_caps, m_held, m_pend, m_ovf;
  logic [17:0] m_pend_ev;
  logic [7:0]  m_leds;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] special_codes [5] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1};

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit ext, input bit brk);
    if (brk) return 8'h00;
    if (ext) return (c == 8'h5A) ? 8'h0D : 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return ((m_lsh || m_rsh) != m_caps) ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return 8'(48 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_caps = 0; m_held = 0;
    m_pend = 0; m_ovf = 0; m_pend_ev = '0; m_leds = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_edge(input logic [7:0] b, input bit rdy);
    int   size_before;
    bit   pop_m;
    logic [7:0] asc;
    size_before = exp_q.size();
    pop_m = rdy && (size_before > 0);
    if (pop_m) void'(exp_q.pop_front());
    if (m_pend) begin
      if (!m_pend_ev[16] && m_pend_ev[7:0] != 8'h00) m_leds = m_pend_ev[7:0];
      if (size_before < DEPTH || pop_m) exp_q.push_back(m_pend_ev);
      else m_ovf = 1;
    end
    m_pend = 0;
    if (b != 8'h00) begin
      if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0 && !(m_ext && m_brk)) begin
        m_brk = 1;
      end else if (!m_ext && !m_brk && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1})) begin
        // status byte, no event
      end else begin
        asc = model_ascii(b, m_ext, m_brk);
        m_pend = 1;
        m_pend_ev = {m_ext, m_brk, b, asc};
        if (!m_ext) begin
          if (b == 8'h12) m_lsh = !m_brk;
          if (b == 8'h59) m_rsh = !m_brk;
          if (b == 8'h58) begin
            if (!m_brk) begin
              if (!m_held) m_caps = !m_caps;
              m_held = 1;
            end else m_held = 0;
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
  endtask

  task automatic step(input logic [7:0] b, input bit rdy);
    data_in = b;
    ev_ready = rdy;
    @(posedge clk);
    model_edge(b, rdy);
    #1;
    data_in = 8'h00;
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 8'h00;
      4:       return letter_codes[$urandom_range(0, 25)];
      5:       return ($urandom_range(0, 3) == 0) ? 8'h29 :
                      ($urandom_range(0, 2) == 0) ? 8'h5A : digit_codes[$urandom_range(0, 9)];
      6:       return ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
      7:       return 8'h58;
      8:       return ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0;
      default: return ($urandom_range(0, 1) == 0) ? special_codes[$urandom_range(0, 4)]
                                                   : 8'($urandom_range(1, 255));
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #3;
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ev_valid); end
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL reset_head: got %h expected 00000", obs); end
    checks++;
    if (leds !== 8'h00 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_leds_ovf: got leds=%h ovf=%b expected 00/0", leds, overflow);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_make_break();
    do_reset();
    step(8'h1C, 0);
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL latency_k: got valid=%b expected 0", ev_valid); end
    step(8'h00, 0);
    checks++;
    if (ev_valid !== 1'b1 || obs !== {2'b00, 8'h1C, 8'h61}) begin
      errors++; $display("FAIL make_1c: got v=%b %h expected 1 %h", ev_valid, obs, {2'b00, 8'h1C, 8'h61});
    end
    step(8'h00, 1);
    step(8'hF0, 0); step(8'h1C, 0); step(8'h00, 0);
    checks++;
    if (obs !== {2'b01, 8'h1C, 8'h00}) begin
      errors++; $display("FAIL break_1c: got %h expected %h", obs, {2'b01, 8'h1C, 8'h00});
    end
    checks++;
    if (leds !== 8'h61) begin errors++; $display("FAIL leds_a: got %h expected 61", leds); end
    step(8'h00, 1);
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL drained: got %b expected 0", ev_valid); end
  endtask

  task automatic test_shift();
    do_reset();
    step(8'h12, 0); step(8'h1C, 0); step(8'h00, 0);
    checks++;
    if (obs !== {2'b00, 8'h12, 8'h00}) begin
      errors++; $display("FAIL shift_make: got %h expected %h", obs, {2'b00, 8'h12, 8'h00});
    end
    step(8'h00, 1);
    checks++;
    if (obs !== {2'b00, 8'h1C, 8'h41}) begin
      errors++; $display("FAIL shift_upper: got %h expected %h", obs, {2'b00, 8'h1C, 8'h41});
    end
    step(8'h00, 1);
    step(8'hF0, 0); step(8'h12, 0); step(8'h1C, 0); step(8'h00, 0);
    checks++;
    if (obs !== {2'b01, 8'h12, 8'h00}) begin
      errors++; $display("FAIL shift_break: got %h expected %h", obs, {2'b01, 8'h12, 8'h00});
    end
    step(8'h00, 1);
    checks++;
    if (obs !== {2'b00, 8'h1C, 8'h61}) begin
      errors++; $display("FAIL shift_lower: got %h expected %h", obs, {2'b00, 8'h1C, 8'h61});
    end
    step(8'h00, 1);
  endtask

  task automatic test_ext_break();
    do_reset();
    step(8'hE0, 0); step(8'hF0, 0); step(8'h75, 0); step(8'h00, 0);
    checks++;
    if (ev_valid !== 1'b1 || obs !== {2'b11, 8'h75, 8'h00}) begin
      errors++; $display("FAIL ext_break: got v=%b %h expected 1 %h", ev_valid, obs, {2'b11, 8'h75, 8'h00});
    end
    step(8'h00, 1);
    step(8'hAA, 0); step(8'h00, 0); step(8'h00, 0);
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL idle_aa: got valid=%b expected 0", ev_valid); end
  endtask

  task automatic test_caps();
    do_reset();
    step(8'h58, 0); step(8'h58, 0); step(8'hF0, 0); step(8'h58, 0); step(8'h1C, 0); step(8'h00, 0);
    step(8'h00, 1); step(8'h00, 1); step(8'h00, 1);
    checks++;
    if (obs !== {2'b00, 8'h1C, 8'h41}) begin
      errors++; $display("FAIL caps_on: got %h expected %h", obs, {2'b00, 8'h1C, 8'h41});
    end
    step(8'h00, 1);
    step(8'h58, 0); step(8'h1C, 0); step(8'h00, 0); step(8'h00, 1);
    checks++;
    if (obs !== {2'b00, 8'h1C, 8'h61}) begin
      errors++; $display("FAIL caps_off: got %h expected %h", obs, {2'b00, 8'h1C, 8'h61});
    end
    step(8'h00, 1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(letter_codes[i], 0);
      if (i == 8) begin
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full: got %b expected 0", overflow); end
      end
    end
    step(8'h00, 0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++;
    if (leds !== 8'h69) begin errors++; $display("FAIL leds_dropped: got %h expected 69", leds); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ev_valid !== 1'b1 || obs !== {2'b00, letter_codes[i], 8'(97 + i)}) begin
        errors++; $display("FAIL fifo_order[%0d]: got v=%b %h expected 1 %h", i, ev_valid, obs,
                           {2'b00, letter_codes[i], 8'(97 + i)});
      end
      step(8'h00, 1);
    end
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", ev_valid); end
  endtask

  task automatic test_reset_mid_prefix();
    do_reset();
    step(8'h1C, 0); step(8'h00, 0); step(8'hE0, 0);
    rst = 1'b1;
    #2;
    checks++;
    if (ev_valid !== 1'b0 || leds !== 8'h00) begin
      errors++; $display("FAIL async_reset: got v=%b leds=%h expected 0/00", ev_valid, leds);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(8'h1C, 0); step(8'h00, 0);
    checks++;
    if (obs !== {2'b00, 8'h1C, 8'h61}) begin
      errors++; $display("FAIL prefix_discard: got %h expected %h", obs, {2'b00, 8'h1C, 8'h61});
    end
    step(8'h00, 1);
  endtask

  task automatic test_full_push_pop();
    int n;
    do_reset();
    for (int i = 0; i < 8; i++) step(letter_codes[i], 0);
    step(8'h00, 0);
    step(letter_codes[8], 0);
    step(8'h00, 1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b expected 0", overflow); end
    checks++;
    if (obs !== {2'b00, letter_codes[1], 8'h62}) begin
      errors++; $display("FAIL full_pushpop_head: got %h expected %h", obs, {2'b00, letter_codes[1], 8'h62});
    end
    n = 0;
    while (ev_valid && n < 20) begin
      step(8'h00, 1);
      n++;
    end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 8", n); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_head;
    int rate;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rate = (c < 400) ? 15 : 70;
      step(rand_byte(), ($urandom_range(0, 99) < rate));
      exp_head = (exp_q.size() != 0) ? exp_q[0] : 18'h0;
      checks++;
      if (ev_valid !== (exp_q.size() != 0) || obs !== exp_head) begin
        errors++; $display("FAIL rand_head c=%0d: got v=%b %h expected v=%b %h", c, ev_valid, obs,
                           (exp_q.size() != 0), exp_head);
      end
      checks++;
      if (leds !== m_leds || overflow !== m_ovf) begin
        errors++; $display("FAIL rand_leds_ovf c=%0d: got %h/%b expected %h/%b", c, leds, overflow, m_leds, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift();
    test_ext_break();
    test_caps();
    test_overflow();
    test_reset_mid_prefix();
    test_full_push_pop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO depth; SHALL be a power of two, 2 to 16.
REQ-002 clk  input  1  board clock, the same clock as the upstream PS/2 receiver; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 data_in  input  8  scan-code byte from the PS/2 receiver; a nonzero value held for one clk cycle SHALL count as one received byte; 0x00 SHALL mean no byte.
REQ-005 ev_ready  input  1  consumer pop request for the FIFO head.
REQ-006 ev_valid  output  1  FIFO not empty.
REQ-007 ev_code  output  8  FIFO head scan code.
REQ-008 ev_ext  output  1  FIFO head extended flag (E0 prefix).
REQ-009 ev_break  output  1  FIFO head release flag (F0 prefix).
REQ-010 ev_ascii  output  8  FIFO head ASCII value; 0x00 means none.
REQ-011 leds  output  8  ASCII of the most recent make event with nonzero ASCII.
REQ-012 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 Prefix FSM states SHALL be IDLE, E0, F0 and E0F0.
REQ-014 FSM transitions SHALL be:
- IDLE, byte 0xE0 -> E0; IDLE, byte 0xF0 -> F0.
- E0, byte 0xF0 -> E0F0.
- Any state, byte 0xE0 -> E0 (restart). F0, byte 0xF0 -> F0.
- Any other byte SHALL complete an event and return the FSM to IDLE.
REQ-015 In IDLE, bytes 0xAA, 0xFA, 0xFE, 0xEE, 0xE1 and 0x00 SHALL be discarded with no event; in F0, E0 and E0F0 these bytes SHALL be treated as codes.
REQ-016 Event fields SHALL be: code = completing byte; ext = 1 iff the state was E0 or E0F0; break = 1 iff the state was F0 or E0F0.
REQ-017 Latency: if the completing byte is sampled at edge k, the decoded event SHALL be registered at edge k and written to the FIFO at edge k+1; ev_valid SHALL read 1 after edge k+1.
REQ-018 Shift tracking: lshift (code 0x12) and rshift (code 0x59), non-extended only, SHALL be set on make and cleared on break.
REQ-019 Caps lock: a non-extended make of 0x58 SHALL toggle caps only when caps_held=0; caps_held SHALL be set on make of 0x58 and cleared on break of 0x58, so typematic repeats SHALL NOT re-toggle.
REQ-020 ASCII rules, using the shift/caps state before the current event updates it:
- Set-2 letters: 0x61-0x7A, or 0x41-0x5A when (lshift|rshift) XOR caps.
- Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46: '0'-'9'; shift SHALL be ignored.
- 0x29 -> 0x20; 0x5A -> 0x0D with ext either 0 or 1.
- All other codes, all other extended codes, and all break events: 0x00.
REQ-021 FIFO push rules:
- A push when full SHALL be dropped and SHALL set overflow.
- A push and a pop in the same cycle when full SHALL both be accepted.
REQ-022 A pop (ev_ready=1) while empty SHALL be ignored; a push and a pop in the same cycle while empty SHALL leave the pushed event at the head.
REQ-023 ev_* outputs SHALL reflect the FIFO head combinationally from storage; when empty, ev_code, ev_ascii, ev_ext and ev_break SHALL read 0.
REQ-024 leds SHALL update at the FIFO-write edge of any make event whose ascii != 0, even if that event is dropped.
REQ-025 Pointer arithmetic SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-026 While rst=1, the following SHALL hold:
- FSM = IDLE.
- lshift, rshift, caps and caps_held = 0.
- FIFO empty; ev_valid = 0.
- leds = 0x00; overflow = 0.
- The pending decoded event SHALL be cleared.
REQ-027 Reset asserted mid-prefix SHALL discard the prefix; the first byte after release SHALL decode from IDLE.

Structure
REQ-028 A shared package ps2_pkg SHALL hold the FSM state enum, prefix constants (0xE0, 0xF0), the special-code list and the event-word struct {ext, brk, code[7:0], ascii[7:0]}.
REQ-029 The set-2-to-ASCII mapping SHALL be the combinational sub-module ps2_ascii_lut (inputs: code, ext, upper; output: ascii).
REQ-030 The FIFO SHALL be inline; no other sub-modules.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Bytes 0x1C, then 0xF0 0x1C -> two events: {code 1C, ext 0, brk 0, ascii 0x61}, then {1C, 0, 1, 0x00}; leds=0x61.
- Bytes 0x12, 0x1C -> second event ascii=0x41; then F0 12, 1C -> ascii=0x61.
- Bytes E0 F0 75 -> one event {75, ext 1, brk 1, ascii 00}; byte 0xAA in IDLE -> no event.
- Bytes 58, 58, F0 58, 1C -> caps=1 and the 1C event ascii=0x41; a second 58 make clears caps.
- 9 make events with ev_ready=0 -> 8 stored, overflow=1; then 8 pops -> ev_valid=0, and head order matches push order.
- Byte E0, rst pulse, then 1C -> ext=0, ascii=0x61; full FIFO with simultaneous push and pop -> count stays 8, overflow stays 0.
